// File: rtl/demux_1t3_buf.sv
// demux_1t3_buf: routes one input stream to one of three output ports chosen
// by SEL. Each output port has a single holding register (valid + data).
// A word with SEL=3 is dropped, pulses ERR for one cycle and bumps a
// saturating drop counter.
//
// Handshake: a transfer happens on a rising edge where VALID and READY are
// both 1. VALID never waits on READY, a held word stays stable until taken,
// and IN_READY is a function of SEL, the slot state and the sink's READY only
// (never of IN_VALID).
module demux_1t3_buf #(
  parameter int n = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [1:0]   SEL,
  input  logic [n-1:0] D_IN,
  output logic         D0_VALID,
  input  logic         D0_READY,
  output logic [n-1:0] D0_OUT,
  output logic         D1_VALID,
  input  logic         D1_READY,
  output logic [n-1:0] D1_OUT,
  output logic         D2_VALID,
  input  logic         D2_READY,
  output logic [n-1:0] D2_OUT,
  output logic         ERR,
  output logic [7:0]   DROP_CNT
);

  logic [2:0]   vld_q;
  logic [n-1:0] data_q [3];
  logic [2:0]   rdy;
  logic [2:0]   wr;
  logic [2:0]   rd;
  logic         in_ready_c;
  logic         in_xfer;
  logic         bad_xfer;
  logic         err_q;
  logic [7:0]   drop_q;

  assign rdy = {D2_READY, D1_READY, D0_READY};

  // Slot for the addressed port is free, or is being drained this same edge.
  always_comb begin
    in_ready_c = 1'b1;
    case (SEL)
      2'd0:    in_ready_c = !vld_q[0] || rdy[0];
      2'd1:    in_ready_c = !vld_q[1] || rdy[1];
      2'd2:    in_ready_c = !vld_q[2] || rdy[2];
      default: in_ready_c = 1'b1;
    endcase
  end

  assign in_xfer  = IN_VALID && in_ready_c;
  assign bad_xfer = in_xfer && (SEL == 2'd3);

  // Per-port write strobe and drain strobe.
  always_comb begin
    wr = 3'b000;
    rd = 3'b000;
    for (int k = 0; k < 3; k++) begin
      wr[k] = in_xfer && (SEL == k[1:0]);
      rd[k] = vld_q[k] && rdy[k];
    end
  end

  // Holding registers: a write wins over a drain so a port sustains one word
  // per cycle; data is only reloaded on a write, so it holds otherwise.
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_q <= 3'b000;
      for (int k = 0; k < 3; k++) data_q[k] <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (wr[k]) begin
          vld_q[k]  <= 1'b1;
          data_q[k] <= D_IN;
        end else if (rd[k]) begin
          vld_q[k]  <= 1'b0;
        end
      end
    end
  end

  // Drop reporting: ERR mirrors the previous cycle's illegal transfer, the
  // counter sticks at 255 instead of wrapping.
  always_ff @(posedge CLK) begin
    if (RST) begin
      err_q  <= 1'b0;
      drop_q <= 8'd0;
    end else begin
      err_q <= bad_xfer;
      if (bad_xfer && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
    end
  end

  assign IN_READY = in_ready_c;
  assign D0_VALID = vld_q[0];
  assign D1_VALID = vld_q[1];
  assign D2_VALID = vld_q[2];
  assign D0_OUT   = data_q[0];
  assign D1_OUT   = data_q[1];
  assign D2_OUT   = data_q[2];
  assign ERR      = err_q;
  assign DROP_CNT = drop_q;

endmodule

// File: tb/tb_demux_1t3_buf.sv
// Testbench for demux_1t3_buf: directed scenarios followed by random traffic,
// each cycle compared against a per-port "one word in flight" reference model.
module tb_demux_1t3_buf;

  localparam int N = 32;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         IN_VALID = 1'b0;
  logic         IN_READY;
  logic [1:0]   SEL = 2'd3;
  logic [N-1:0] D_IN = '0;
  logic         D0_VALID, D1_VALID, D2_VALID;
  logic         D0_READY = 1'b0, D1_READY = 1'b0, D2_READY = 1'b0;
  logic [N-1:0] D0_OUT, D1_OUT, D2_OUT;
  logic         ERR;
  logic [7:0]   DROP_CNT;

  int checks = 0;
  int errors = 0;

  // Reference model: each port either holds one word or is empty; the last
  // word shown on a port persists after it is taken.
  bit           m_full [3];
  logic [N-1:0] m_word [3];
  bit           m_err;
  int           m_drops;

  // Clock generation.
  always #5 CLK = ~CLK;

  demux_1t3_buf #(.n(N)) dut (
    .CLK(CLK), .RST(RST),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .SEL(SEL), .D_IN(D_IN),
    .D0_VALID(D0_VALID), .D0_READY(D0_READY), .D0_OUT(D0_OUT),
    .D1_VALID(D1_VALID), .D1_READY(D1_READY), .D1_OUT(D1_OUT),
    .D2_VALID(D2_VALID), .D2_READY(D2_READY), .D2_OUT(D2_OUT),
    .ERR(ERR), .DROP_CNT(DROP_CNT)
  );

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] outs [3];
    logic         vlds [3];
    outs[0] = D0_OUT;   outs[1] = D1_OUT;   outs[2] = D2_OUT;
    vlds[0] = D0_VALID; vlds[1] = D1_VALID; vlds[2] = D2_VALID;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("valid%0d", k), {31'd0, vlds[k]}, {31'd0, m_full[k]});
      check($sformatf("out%0d", k), outs[k], m_word[k]);
    end
    check("err", {31'd0, ERR}, {31'd0, m_err});
    check("drop_cnt", {24'd0, DROP_CNT}, m_drops);
  endtask

  // One clock cycle: drive inputs just after an edge, check IN_READY before
  // the next edge, advance the model at the edge, then check the outputs.
  task automatic cyc(input bit iv, input logic [1:0] sel, input logic [N-1:0] d,
                     input logic [2:0] rdy, input bit rst);
    bit exp_ready;
    bit acc;
    IN_VALID = iv; SEL = sel; D_IN = d; RST = rst;
    D0_READY = rdy[0]; D1_READY = rdy[1]; D2_READY = rdy[2];
    #1;
    exp_ready = (sel == 2'd3) ? 1'b1 : (!m_full[sel] || rdy[sel]);
    check("in_ready", {31'd0, IN_READY}, {31'd0, exp_ready});
    @(posedge CLK);
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        m_full[k] = 1'b0;
        m_word[k] = '0;
      end
      m_err = 1'b0;
      m_drops = 0;
    end else begin
      acc = iv && exp_ready;
      for (int k = 0; k < 3; k++) begin
        if (acc && sel == k) begin
          m_full[k] = 1'b1;
          m_word[k] = d;
        end else if (m_full[k] && rdy[k]) begin
          m_full[k] = 1'b0;
        end
      end
      m_err = acc && (sel == 2'd3);
      if (m_err && m_drops < 255) m_drops++;
    end
    #1;
    check_outputs();
  endtask

  initial begin
    logic [1:0] rsel;
    for (int k = 0; k < 3; k++) begin
      m_full[k] = 1'b0;
      m_word[k] = '0;
    end
    m_err = 1'b0;
    m_drops = 0;

    // Reset; SEL=3 keeps IN_READY defined before the first edge.
    cyc(0, 2'd3, '0, 3'b000, 1);
    cyc(0, 2'd3, '0, 3'b000, 1);
    check("reset_valid1", {31'd0, D1_VALID}, 32'd0);
    check("reset_cnt", {24'd0, DROP_CNT}, 32'd0);

    // Basic routing with one-cycle latency.
    cyc(1, 2'd1, 32'hDEADBEEF, 3'b000, 0);
    check("route_out1", D1_OUT, 32'hDEADBEEF);
    check("route_valid0", {31'd0, D0_VALID}, 32'd0);
    cyc(0, 2'd0, '0, 3'b010, 0);

    // Full slot stalls the source, release lets the next word in.
    cyc(1, 2'd0, 32'h11, 3'b000, 0);
    cyc(1, 2'd0, 32'h22, 3'b000, 0);
    check("stall_ready", {31'd0, IN_READY}, 32'd0);
    check("stall_out0", D0_OUT, 32'h11);
    cyc(1, 2'd0, 32'h22, 3'b001, 0);
    check("release_out0", D0_OUT, 32'h22);
    check("release_valid0", {31'd0, D0_VALID}, 32'd1);
    cyc(0, 2'd0, '0, 3'b001, 0);

    // Sustained one word per cycle on port 2.
    for (int i = 1; i <= 4; i++) begin
      cyc(1, 2'd2, N'(i), 3'b100, 0);
      check("stream_out2", D2_OUT, N'(i));
      check("stream_valid2", {31'd0, D2_VALID}, 32'd1);
    end
    cyc(0, 2'd0, '0, 3'b100, 0);

    // Illegal select: drops, ERR pulses, saturation.
    for (int i = 0; i < 3; i++) begin
      cyc(1, 2'd3, N'($urandom), 3'b000, 0);
      check("illegal_err", {31'd0, ERR}, 32'd1);
    end
    check("illegal_cnt3", {24'd0, DROP_CNT}, 32'd3);
    cyc(0, 2'd3, '0, 3'b000, 0);
    check("illegal_err_off", {31'd0, ERR}, 32'd0);
    for (int i = 0; i < 300; i++) cyc(1, 2'd3, N'($urandom), 3'b000, 0);
    check("illegal_sat", {24'd0, DROP_CNT}, 32'd255);

    // Reset mid-operation with every port full.
    cyc(0, 2'd3, '0, 3'b000, 1);
    for (int i = 0; i < 5; i++) cyc(1, 2'd3, '0, 3'b000, 0);
    cyc(1, 2'd0, 32'hA0, 3'b000, 0);
    cyc(1, 2'd1, 32'hA1, 3'b000, 0);
    cyc(1, 2'd2, 32'hA2, 3'b000, 0);
    check("prereset_cnt", {24'd0, DROP_CNT}, 32'd5);
    cyc(1, 2'd0, 32'hAA, 3'b000, 1);
    check("midreset_out2", D2_OUT, 32'd0);
    check("midreset_valid0", {31'd0, D0_VALID}, 32'd0);
    check("midreset_cnt", {24'd0, DROP_CNT}, 32'd0);

    // Independent ports: drain 0, write 1, leave 2 full.
    cyc(1, 2'd0, 32'h10, 3'b000, 0);
    cyc(1, 2'd2, 32'h12, 3'b000, 0);
    cyc(1, 2'd1, 32'h55, 3'b001, 0);
    check("indep_valid0", {31'd0, D0_VALID}, 32'd0);
    check("indep_out1", D1_OUT, 32'h55);
    check("indep_out2", D2_OUT, 32'h12);

    // Random traffic, occasional reset.
    for (int i = 0; i < 400; i++) begin
      rsel = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      cyc(1'($urandom_range(0, 1)), rsel, N'($urandom), 3'($urandom_range(0, 7)),
          $urandom_range(0, 49) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_1t3_buf.md
DEMUX_1T3_BUF -- requirements
Module: demux_1t3_buf

Interface
REQ-001 Parameter: n, default 32, data width of the input and each output port.
REQ-002 The port list SHALL be exactly as follows; clock and reset are listed first. One clock; reset is synchronous and active-high.
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous active-high reset.
- IN_VALID  input  1  the source presents a word.
- IN_READY  output  1  the block accepts the word this cycle.
- SEL  input  2  destination port: 0, 1 or 2; 3 is illegal.
- D_IN  input  n  input data.
- Dk_VALID  output  1  (k = 0,1,2) output port k holds a word.
- Dk_READY  input  1  (k = 0,1,2) the sink of port k takes the word.
- Dk_OUT  output  n  (k = 0,1,2) output data of port k.
- ERR  output  1  one-cycle pulse: an illegal-SEL word was dropped.
- DROP_CNT  output  8  count of dropped words, saturating.

Function
REQ-003 Each output port k SHALL contain one holding register: a valid bit plus n data bits.
REQ-004 Transfers:
- An input transfer occurs on a rising edge with IN_VALID=1 and IN_READY=1.
- An output transfer on port k occurs on a rising edge with Dk_VALID=1 and Dk_READY=1.
REQ-005 IN_READY SHALL be combinational from SEL, the slot state and Dk_READY:
- SEL=3: IN_READY=1.
- Otherwise: IN_READY = !Dk_VALID || Dk_READY, where k=SEL.
REQ-006 IN_READY SHALL NOT depend on IN_VALID.
REQ-007 Write to port SEL=k on an input transfer:
- Dk_OUT <= D_IN and Dk_VALID <= 1 at that edge.
- The word is visible on Dk_OUT from the next cycle, so latency is 1 cycle.
REQ-008 On an output transfer on port k with no simultaneous input transfer to k, Dk_VALID SHALL clear at that edge.
REQ-009 Simultaneous output transfer on k and input transfer to k in the same edge:
- Dk_VALID SHALL stay 1 and Dk_OUT SHALL take the new D_IN.
- This gives one word per cycle sustained per port.
REQ-010 While Dk_VALID=1 and Dk_READY=0, Dk_OUT SHALL hold stable.
REQ-011 When Dk_VALID=0, Dk_OUT SHALL retain its last value.
REQ-012 Ports not addressed by SEL SHALL be unaffected by an input transfer, other than their own drains.
REQ-013 Input transfer with SEL=3:
- The word SHALL be discarded.
- ERR SHALL be 1 for exactly the next cycle.
- DROP_CNT SHALL increment by 1, saturating at 255 (no wrap).
REQ-014 ERR SHALL be 0 in every cycle not following an illegal-SEL transfer.
REQ-015 Back-to-back illegal transfers SHALL hold ERR at 1 and increment DROP_CNT once per transfer.
REQ-016 The three output ports SHALL drain independently; any combination of Dk_READY may be asserted in the same cycle.
REQ-017 Word order SHALL be preserved per port. No ordering is guaranteed across ports.
REQ-018 Dk_VALID SHALL never deassert without an output transfer on k, except by reset.
REQ-019 SEL and D_IN SHALL be ignored when IN_VALID=0.

Reset
REQ-020 On a rising edge with RST=1, the following SHALL be cleared:
- D0_VALID, D1_VALID, D2_VALID = 0.
- D0_OUT, D1_OUT, D2_OUT = 0.
- ERR = 0.
- DROP_CNT = 0.
REQ-021 RST SHALL take priority over any simultaneous input or output transfer; in-flight held words are lost.
REQ-022 During reset, IN_READY SHALL follow REQ-005 using the cleared state, so it reads 1 in the cycle after the reset edge.

Verification
REQ-023 Basic routing, one-cycle latency:
- Stimulus: after reset, IN_VALID=1, SEL=1, D_IN=0xDEADBEEF for 1 cycle; all Dk_READY=0.
- Response: next cycle D1_VALID=1, D1_OUT=0xDEADBEEF; D0_VALID=0, D2_VALID=0.
REQ-024 Full-slot stall then release:
- Stimulus: port 0 holding 0x11 with D0_READY=0; present SEL=0, D_IN=0x22.
- Response: IN_READY=0 and D0_OUT stays 0x11. Raise D0_READY=1: IN_READY=1 in the same cycle, and the next cycle D0_OUT=0x22, D0_VALID=1.
REQ-025 Sustained throughput:
- Stimulus: SEL=2, D_IN=1,2,3,4 on consecutive cycles with D2_READY=1 throughout.
- Response: D2_OUT=1,2,3,4 on consecutive cycles, D2_VALID continuously 1, IN_READY continuously 1.
REQ-026 Illegal select:
- Stimulus: SEL=3 with IN_VALID=1 for 3 consecutive cycles.
- Response: IN_READY=1 throughout; ERR=1 for 3 cycles starting 1 cycle later; DROP_CNT=3; all Dk_VALID=0.
- Stimulus: 300 further illegal transfers.
- Response: DROP_CNT=255.
REQ-027 Reset mid-operation:
- Stimulus: all three ports full with Dk_READY=0, DROP_CNT=5; assert RST for 1 cycle together with IN_VALID=1, SEL=0.
- Response: next cycle all Dk_VALID=0, all Dk_OUT=0, DROP_CNT=0, ERR=0, IN_READY=1.
REQ-028 Independent ports:
- Stimulus: ports 0 and 2 full; assert D0_READY=1 and D2_READY=0 while writing SEL=1, D_IN=0x55.
- Response: next cycle D0_VALID=0, D1_VALID=1 with D1_OUT=0x55, D2_VALID=1 unchanged.
